// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: a scoreboard of long-latency destination
// registers, the per-stage stall vector, and a stall FSM whose watchdog
// traps a pipeline stuck on a hazard that never resolves.
module hazard_ctrl #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid_i,
    input  logic                id_reg1_read_i,
    input  logic [ADDR_W-1:0]   id_reg1_addr_i,
    input  logic                id_reg2_read_i,
    input  logic [ADDR_W-1:0]   id_reg2_addr_i,
    input  logic                id_wreg_i,
    input  logic [ADDR_W-1:0]   id_wd_i,
    input  logic                id_long_i,
    input  logic                wb_done_i,
    input  logic [ADDR_W-1:0]   wb_wd_i,
    input  logic                mem_stallreq_i,
    input  logic                flush_i,
    output logic [5:0]          stall_o,
    output logic [REG_NUM-1:0]  pending_o,
    output logic [ADDR_W:0]     pend_cnt_o,
    output logic                err_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HAZ  = 2'd1,
        ST_MSTL = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Scoreboard lookup; register 0 is hard-wired and never tracked.
    function automatic logic pend_at(input logic [REG_NUM-1:0] vec,
                                     input logic [ADDR_W-1:0]  addr);
        logic hit;
        if (addr == {ADDR_W{1'b0}}) begin
            hit = 1'b0;
        end else begin
            hit = vec[addr];
        end
        return hit;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [WD_W-1:0]     wd_r;
    logic [WD_W-1:0]     wd_next_s;
    logic [REG_NUM-1:0]  pending_r;
    logic [REG_NUM-1:0]  pending_next_s;
    logic [REG_NUM-1:0]  pend_eff_s;
    logic [REG_NUM-1:0]  set_vec_s;
    logic [REG_NUM-1:0]  clr_vec_s;
    logic [ADDR_W:0]     pend_cnt_r;
    logic [ADDR_W:0]     pend_cnt_next_s;
    logic                err_r;
    logic                haz_s;
    logic                issue_s;
    logic                set_en_s;
    logic                inc_s;
    logic                dec_s;
    logic [5:0]          stall_s;

    // Effective scoreboard: a completing writeback is already forwardable.
    always_comb begin
        pend_eff_s = {REG_NUM{1'b0}};
        for (int i = 0; i < REG_NUM; i++) begin
            pend_eff_s[i] = pending_r[i] & ~(wb_done_i && (wb_wd_i == ADDR_W'(i)));
        end
    end

    // RAW on either source plus WAW on the destination, and the issue condition.
    always_comb begin
        haz_s = id_valid_i &
                ((id_reg1_read_i & pend_at(pend_eff_s, id_reg1_addr_i)) |
                 (id_reg2_read_i & pend_at(pend_eff_s, id_reg2_addr_i)) |
                 (id_wreg_i      & pend_at(pend_eff_s, id_wd_i)));
        issue_s  = id_valid_i & ~haz_s & ~mem_stallreq_i & ~flush_i & (state_r != ST_ERR);
        set_en_s = issue_s & id_wreg_i & id_long_i & (id_wd_i != {ADDR_W{1'b0}});
    end

    // Set/clear vectors and the next scoreboard; a same-register set wins over the clear.
    always_comb begin
        set_vec_s = {REG_NUM{1'b0}};
        clr_vec_s = {REG_NUM{1'b0}};
        for (int i = 1; i < REG_NUM; i++) begin
            set_vec_s[i] = set_en_s  && (id_wd_i == ADDR_W'(i));
            clr_vec_s[i] = wb_done_i && (wb_wd_i == ADDR_W'(i));
        end
        pending_next_s = (pending_r & ~clr_vec_s) | set_vec_s;
    end

    // Incremental population count kept in step with the scoreboard.
    always_comb begin
        inc_s = set_en_s & ~pending_r[id_wd_i];
        dec_s = wb_done_i & pend_at(pending_r, wb_wd_i) &
                ~(set_en_s && (id_wd_i == wb_wd_i));
        pend_cnt_next_s = pend_cnt_r + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};
    end

    // Stall FSM next state and watchdog; the watchdog clears whenever RUN is entered.
    always_comb begin
        state_next_s = state_r;
        wd_next_s    = wd_r;
        case (state_r)
            ST_RUN: begin
                if (mem_stallreq_i) begin
                    state_next_s = ST_MSTL;
                end else if (haz_s && !flush_i) begin
                    state_next_s = ST_HAZ;
                    wd_next_s    = {WD_W{1'b0}};
                end else begin
                    state_next_s = ST_RUN;
                    wd_next_s    = {WD_W{1'b0}};
                end
            end
            ST_HAZ: begin
                if (mem_stallreq_i) begin
                    state_next_s = ST_MSTL;
                end else if (!haz_s || flush_i) begin
                    state_next_s = ST_RUN;
                    wd_next_s    = {WD_W{1'b0}};
                end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_HAZ;
                    wd_next_s    = wd_r + WD_W'(1);
                end
            end
            ST_MSTL: begin
                if (!mem_stallreq_i) begin
                    state_next_s = ST_RUN;
                    wd_next_s    = {WD_W{1'b0}};
                end else begin
                    state_next_s = ST_MSTL;
                end
            end
            ST_ERR: begin
                state_next_s = ST_ERR;
            end
            default: begin
                state_next_s = ST_RUN;
                wd_next_s    = {WD_W{1'b0}};
            end
        endcase
    end

    // Per-stage stall vector, prioritised; forced idle while reset is held.
    always_comb begin
        if (!rst) begin
            stall_s = 6'b000000;
        end else if (state_r == ST_ERR) begin
            stall_s = 6'b111111;
        end else if (mem_stallreq_i) begin
            stall_s = 6'b011111;
        end else if (flush_i) begin
            stall_s = 6'b000000;
        end else if (haz_s) begin
            stall_s = 6'b000111;
        end else begin
            stall_s = 6'b000000;
        end
    end

    // State, watchdog, scoreboard, count and sticky trap registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_RUN;
            wd_r       <= {WD_W{1'b0}};
            pending_r  <= {REG_NUM{1'b0}};
            pend_cnt_r <= {(ADDR_W+1){1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wd_r       <= wd_next_s;
            pending_r  <= pending_next_s;
            pend_cnt_r <= pend_cnt_next_s;
            err_r      <= err_r | (state_next_s == ST_ERR);
        end
    end

    assign stall_o    = stall_s;
    assign pending_o  = pending_r;
    assign pend_cnt_o = pend_cnt_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid_i;
    logic        id_reg1_read_i;
    logic [4:0]  id_reg1_addr_i;
    logic        id_reg2_read_i;
    logic [4:0]  id_reg2_addr_i;
    logic        id_wreg_i;
    logic [4:0]  id_wd_i;
    logic        id_long_i;
    logic        wb_done_i;
    logic [4:0]  wb_wd_i;
    logic        mem_stallreq_i;
    logic        flush_i;
    logic [5:0]  stall_o;
    logic [31:0] pending_o;
    logic [5:0]  pend_cnt_o;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(.REG_NUM(32), .ADDR_W(5), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i),
        .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
        .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
        .id_wreg_i(id_wreg_i), .id_wd_i(id_wd_i), .id_long_i(id_long_i),
        .wb_done_i(wb_done_i), .wb_wd_i(wb_wd_i),
        .mem_stallreq_i(mem_stallreq_i), .flush_i(flush_i),
        .stall_o(stall_o), .pending_o(pending_o),
        .pend_cnt_o(pend_cnt_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation ran past its time limit");
        $fatal(1);
    end

    task automatic idle();
        id_valid_i = 1'b0; id_reg1_read_i = 1'b0; id_reg1_addr_i = 5'd0;
        id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0;
        id_wreg_i = 1'b0; id_wd_i = 5'd0; id_long_i = 1'b0;
        wb_done_i = 1'b0; wb_wd_i = 5'd0;
        mem_stallreq_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        id_valid_i = 1'b1; id_wreg_i = 1'b1; id_long_i = 1'b1; id_wd_i = rd;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        mem_stallreq_i = 1'b1;
        step(); step();
        n_vec++; if (stall_o !== 6'b000000) begin n_err++; $display("FAIL reset_stall: got %b expected %b", stall_o, 6'b000000); end
        n_vec++; if (pending_o !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h expected %h", pending_o, 32'h0); end
        n_vec++; if (pend_cnt_o !== 6'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected %0d", pend_cnt_o, 0); end
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected %b", err_o, 1'b0); end
        rst = 1'b1;
        idle();
        step();
        n_vec++; if (stall_o !== 6'b000000) begin n_err++; $display("FAIL post_reset_stall: got %b expected %b", stall_o, 6'b000000); end
    endtask

    task automatic test_load_use();
        idle(); issue_long(5'd5);
        #1;
        n_vec++; if (stall_o !== 6'b000000) begin n_err++; $display("FAIL lu_issue_stall: got %b expected %b", stall_o, 6'b000000); end
        step();
        idle(); id_valid_i = 1'b1; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd5;
        #1;
        n_vec++; if (pending_o !== 32'h0000_0020) begin n_err++; $display("FAIL lu_pending: got %h expected %h", pending_o, 32'h0000_0020); end
        n_vec++; if (pend_cnt_o !== 6'd1) begin n_err++; $display("FAIL lu_cnt: got %0d expected %0d", pend_cnt_o, 1); end
        n_vec++; if (stall_o !== 6'b000111) begin n_err++; $display("FAIL lu_stall: got %b expected %b", stall_o, 6'b000111); end
        repeat (3) step();
        n_vec++; if (stall_o !== 6'b000111) begin n_err++; $display("FAIL lu_stall_held: got %b expected %b", stall_o, 6'b000111); end
        wb_done_i = 1'b1; wb_wd_i = 5'd5;
        #1;
        n_vec++; if (stall_o !== 6'b000000) begin n_err++; $display("FAIL lu_bypass: got %b expected %b", stall_o, 6'b000000); end
        n_vec++; if (pending_o !== 32'h0000_0020) begin n_err++; $display("FAIL lu_pending_wb: got %h expected %h", pending_o, 32'h0000_0020); end
        step();
        idle();
        #1;
        n_vec++; if (pending_o !== 32'h0) begin n_err++; $display("FAIL lu_cleared: got %h expected %h", pending_o, 32'h0); end
        n_vec++; if (pend_cnt_o !== 6'd0) begin n_err++; $display("FAIL lu_cnt_zero: got %0d expected %0d", pend_cnt_o, 0); end
    endtask

    task automatic test_r0();
        idle(); issue_long(5'd0);
        step();
        idle(); id_valid_i = 1'b1;
        id_reg1_read_i = 1'b1; id_reg2_read_i = 1'b1; id_wreg_i = 1'b1;
        #1;
        n_vec++; if (stall_o !== 6'b000000) begin n_err++; $display("FAIL r0_stall: got %b expected %b", stall_o, 6'b000000); end
        n_vec++; if (pending_o !== 32'h0) begin n_err++; $display("FAIL r0_pending: got %h expected %h", pending_o, 32'h0); end
        n_vec++; if (pend_cnt_o !== 6'd0) begin n_err++; $display("FAIL r0_cnt: got %0d expected %0d", pend_cnt_o, 0); end
        step();
        idle();
    endtask

    task automatic test_mem_stall();
        idle(); issue_long(5'd3);
        step();
        idle(); issue_long(5'd9);
        id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd3; mem_stallreq_i = 1'b1;
        #1;
        n_vec++; if (stall_o !== 6'b011111) begin n_err++; $display("FAIL mem_haz_stall: got %b expected %b", stall_o, 6'b011111); end
        step();
        n_vec++; if (pending_o !== 32'h0000_0008) begin n_err++; $display("FAIL mem_no_issue: got %h expected %h", pending_o, 32'h0000_0008); end
        idle(); issue_long(5'd10); mem_stallreq_i = 1'b1;
        #1;
        n_vec++; if (stall_o !== 6'b011111) begin n_err++; $display("FAIL mem_only_stall: got %b expected %b", stall_o, 6'b011111); end
        step();
        n_vec++; if (pending_o !== 32'h0000_0008) begin n_err++; $display("FAIL mem_no_issue2: got %h expected %h", pending_o, 32'h0000_0008); end
        n_vec++; if (pend_cnt_o !== 6'd1) begin n_err++; $display("FAIL mem_cnt: got %0d expected %0d", pend_cnt_o, 1); end
        idle(); wb_done_i = 1'b1; wb_wd_i = 5'd3;
        step();
        idle();
        #1;
        n_vec++; if (pending_o !== 32'h0 || pend_cnt_o !== 6'd0) begin n_err++; $display("FAIL mem_cleanup: got %h/%0d expected %h/%0d", pending_o, pend_cnt_o, 32'h0, 0); end
    endtask

    task automatic test_same_cycle();
        idle(); issue_long(5'd7);
        step();
        idle(); id_valid_i = 1'b1; id_wreg_i = 1'b1; id_wd_i = 5'd7;
        #1;
        n_vec++; if (stall_o !== 6'b000111) begin n_err++; $display("FAIL waw_stall: got %b expected %b", stall_o, 6'b000111); end
        step();
        idle(); issue_long(5'd7); wb_done_i = 1'b1; wb_wd_i = 5'd7;
        #1;
        n_vec++; if (stall_o !== 6'b000000) begin n_err++; $display("FAIL sc_stall: got %b expected %b", stall_o, 6'b000000); end
        step();
        idle();
        #1;
        n_vec++; if (pending_o !== 32'h0000_0080) begin n_err++; $display("FAIL sc_pending: got %h expected %h", pending_o, 32'h0000_0080); end
        n_vec++; if (pend_cnt_o !== 6'd1) begin n_err++; $display("FAIL sc_cnt: got %0d expected %0d", pend_cnt_o, 1); end
        issue_long(5'd4); wb_done_i = 1'b1; wb_wd_i = 5'd12;
        step();
        n_vec++; if (pending_o !== 32'h0000_0090 || pend_cnt_o !== 6'd2) begin n_err++; $display("FAIL b2b_ignore_clr: got %h/%0d expected %h/%0d", pending_o, pend_cnt_o, 32'h0000_0090, 2); end
        idle(); issue_long(5'd6); wb_done_i = 1'b1; wb_wd_i = 5'd7;
        step();
        n_vec++; if (pending_o !== 32'h0000_0050 || pend_cnt_o !== 6'd2) begin n_err++; $display("FAIL b2b_set_clr: got %h/%0d expected %h/%0d", pending_o, pend_cnt_o, 32'h0000_0050, 2); end
        idle(); wb_done_i = 1'b1; wb_wd_i = 5'd4;
        step();
        wb_wd_i = 5'd6;
        step();
        idle();
        n_vec++; if (pending_o !== 32'h0 || pend_cnt_o !== 6'd0) begin n_err++; $display("FAIL b2b_drain: got %h/%0d expected %h/%0d", pending_o, pend_cnt_o, 32'h0, 0); end
    endtask

    task automatic test_reset_mid_flight();
        idle(); issue_long(5'd13);
        step();
        idle();
        n_vec++; if (pending_o !== 32'h0000_2000 || pend_cnt_o !== 6'd1) begin n_err++; $display("FAIL mf_pending: got %h/%0d expected %h/%0d", pending_o, pend_cnt_o, 32'h0000_2000, 1); end
        rst = 1'b0;
        step();
        rst = 1'b1; wb_done_i = 1'b1; wb_wd_i = 5'd13;
        step();
        idle();
        n_vec++; if (pending_o !== 32'h0 || pend_cnt_o !== 6'd0) begin n_err++; $display("FAIL mf_late_clear: got %h/%0d expected %h/%0d", pending_o, pend_cnt_o, 32'h0, 0); end
    endtask

    task automatic test_flush_timeout();
        int bad;
        idle(); issue_long(5'd8);
        step();
        idle(); id_valid_i = 1'b1; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd8;
        #1;
        n_vec++; if (stall_o !== 6'b000111) begin n_err++; $display("FAIL fl_haz_stall: got %b expected %b", stall_o, 6'b000111); end
        repeat (3) step();
        flush_i = 1'b1;
        #1;
        n_vec++; if (stall_o !== 6'b000000) begin n_err++; $display("FAIL fl_stall: got %b expected %b", stall_o, 6'b000000); end
        step();
        flush_i = 1'b0;
        #1;
        n_vec++; if (pending_o !== 32'h0000_0100) begin n_err++; $display("FAIL fl_retained: got %h expected %h", pending_o, 32'h0000_0100); end
        // one RUN cycle plus 64 HAZ cycles of plain hazard stall before the trap
        bad = 0;
        for (int i = 0; i < 65; i++) begin
            if (bad == 0 && (stall_o !== 6'b000111 || err_o !== 1'b0)) begin
                bad = 1;
                n_err++;
                $display("FAIL to_pre_err cycle %0d: got %b/%b expected %b/%b", i, stall_o, err_o, 6'b000111, 1'b0);
            end
            step();
        end
        n_vec++;
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL to_err: got %b expected %b", err_o, 1'b1); end
        n_vec++; if (stall_o !== 6'b111111) begin n_err++; $display("FAIL to_err_stall: got %b expected %b", stall_o, 6'b111111); end
        idle(); issue_long(5'd11); wb_done_i = 1'b1; wb_wd_i = 5'd8;
        step();
        idle();
        n_vec++; if (pending_o !== 32'h0 || pend_cnt_o !== 6'd0) begin n_err++; $display("FAIL err_clear_noissue: got %h/%0d expected %h/%0d", pending_o, pend_cnt_o, 32'h0, 0); end
        n_vec++; if (err_o !== 1'b1 || stall_o !== 6'b111111) begin n_err++; $display("FAIL err_sticky: got %b/%b expected %b/%b", err_o, stall_o, 1'b1, 6'b111111); end
        rst = 1'b0;
        #1;
        n_vec++; if (stall_o !== 6'b000000) begin n_err++; $display("FAIL err_rst_stall: got %b expected %b", stall_o, 6'b000000); end
        step();
        rst = 1'b1;
        #1;
        n_vec++; if (err_o !== 1'b0 || stall_o !== 6'b000000) begin n_err++; $display("FAIL err_released: got %b/%b expected %b/%b", err_o, stall_o, 1'b0, 6'b000000); end
        n_vec++; if (pending_o !== 32'h0 || pend_cnt_o !== 6'd0) begin n_err++; $display("FAIL err_rst_sb: got %h/%0d expected %h/%0d", pending_o, pend_cnt_o, 32'h0, 0); end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_r0();
        test_mem_stall();
        test_same_cycle();
        test_reset_mid_flight();
        test_flush_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 64-bit-instruction, 32 x 32-bit register CPU. A 32-entry scoreboard tracks destination registers of in-flight long-latency ops (loads, multi-cycle ALU ops) that the ex/mem forwarding paths cannot cover. The block generates the per-stage stall vector for pc/if/id/ex/mem/wb from scoreboard hazards and memory stall requests. It runs a stall FSM with a watchdog that traps a stuck pipeline.

Parameters:
REG_NUM, 32, number of architectural registers. Register 0 is never tracked.
ADDR_W, 5, register address width, equal to the RegAddrBus width.
TIMEOUT, 64, maximum number of consecutive hazard-stall cycles before the ERR state.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset: rst==0 sampled at a rising clk edge resets all state
id_valid_i  in  1  ID holds a valid instruction
id_reg1_read_i  in  1  ID reads source 1
id_reg1_addr_i  in  ADDR_W  source 1 address
id_reg2_read_i  in  1  ID reads source 2
id_reg2_addr_i  in  ADDR_W  source 2 address
id_wreg_i  in  1  ID instruction writes a register
id_wd_i  in  ADDR_W  destination address
id_long_i  in  1  ID instruction is long-latency (result not forwardable)
wb_done_i  in  1  a long op writes back this cycle
wb_wd_i  in  ADDR_W  destination of the completing long op
mem_stallreq_i  in  1  memory stage busy
flush_i  in  1  kill the younger instructions (if/id)
stall_o  out  6  {wb,mem,ex,id,if,pc} stall bits, bit0 = pc
pending_o  out  REG_NUM  scoreboard bits
pend_cnt_o  out  ADDR_W+1  number of set pending bits
err_o  out  1  watchdog trap, sticky until reset

Behaviour:
- Reset (rst==0 at an edge): pending_o=0, pend_cnt_o=0, err_o=0, FSM=RUN, watchdog=0. stall_o=0 while reset is asserted.
- Bypass: pend_eff[r] = pending[r] & ~(wb_done_i & wb_wd_i==r). The completing writeback is visible to the regfile and forwarding in the same cycle.
- Hazard: haz = id_valid_i & ((id_reg1_read_i & pend_eff[id_reg1_addr_i]) | (id_reg2_read_i & pend_eff[id_reg2_addr_i]) | (id_wreg_i & pend_eff[id_wd_i])).
  - The last term is a WAW guard.
  - Address 0 never produces a hazard.
- stall_o is combinational from the FSM state and the current inputs, with priority top-down:
  - ERR: 6'b111111.
  - mem_stallreq_i: 6'b011111.
  - flush_i: 6'b000000.
  - haz: 6'b000111. pc/if/id are held; ex receives a bubble.
  - otherwise 6'b000000.
- Issue: issue = id_valid_i & ~haz & ~mem_stallreq_i & ~flush_i & state!=ERR.
  - On issue with id_wreg_i & id_long_i & id_wd_i!=0, set pending[id_wd_i] at the edge.
- Clear: wb_done_i clears pending[wb_wd_i] at the edge.
  - A clear for a register that is not pending is ignored.
  - Clears still occur during flush, mem stall and ERR: in-flight ops always complete.
- Set and clear of the same register in the same cycle: set wins, the bit stays 1, and pend_cnt_o is unchanged.
- pend_cnt_o is a registered count updated by +1 on a set of a clear bit and -1 on a clear of a set bit. It always equals popcount(pending_o) and saturates at neither end.
- FSM states: RUN, HAZ, MSTL, ERR.
  - RUN -> MSTL if mem_stallreq_i; else RUN -> HAZ if haz & ~flush_i.
  - HAZ -> MSTL if mem_stallreq_i; -> RUN if ~haz or flush_i; otherwise stay and increment the watchdog.
  - MSTL -> RUN when mem_stallreq_i drops. The watchdog is held, not cleared, in MSTL.
  - The watchdog clears on entry to RUN.
  - HAZ with watchdog==TIMEOUT-1 and haz still true -> ERR, with err_o=1 from the next cycle.
  - ERR is left only by reset.
- A reset asserted mid-stall or mid-flight discards the whole scoreboard. Completions that arrive later for discarded entries are ignored.

Test Plan:
- Load r5 issued (id_long_i=1, id_wd_i=5), next instruction reads r5 -> stall_o=6'b000111 and pending_o[5]=1 until wb_done_i with wb_wd_i=5. In that cycle stall_o=0 (bypass); the bit clears at the next edge and pend_cnt_o returns 0.
- Long op writes r0 -> no pending bit set, a read of r0 never stalls, pend_cnt_o stays 0.
- mem_stallreq_i=1 while haz=1 -> stall_o=6'b011111. No issue occurs, so a long op in ID sets no pending bit.
- Same-cycle wb_done_i r7 and issue of a long op to r7 -> pending_o[7]=1 and pend_cnt_o unchanged. A WAW case (destination r7 already pending) stalls with 6'b000111.
- Hazard held with no writeback, TIMEOUT=64 -> ERR entered after 64 HAZ cycles: err_o=1 and stall_o=6'b111111. Both persist until rst=0 for one edge, after which all outputs are 0.
- flush_i during a hazard -> stall_o=0, FSM returns to RUN, watchdog resets, and existing pending bits are retained.
